// File: rtl/sevenseg_scan_decoder_if.sv
// Display-bus bundle for the seven-segment scan decoder: sampled pins in,
// recovered frame out.
interface sevenseg_scan_decoder_if;
    logic [0:6]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] value_out;
    logic [3:0]  digit_err_out;
    logic        frame_valid_out;

    modport master (
        output seg_in,
        output an_in,
        input  value_out,
        input  digit_err_out,
        input  frame_valid_out
    );

    modport slave (
        input  seg_in,
        input  an_in,
        output value_out,
        output digit_err_out,
        output frame_valid_out
    );
endinterface

// File: rtl/sevenseg_scan_decoder.sv
// Monitors a multiplexed common-anode 7-segment bus, debounces each digit,
// decodes it back to a hex nibble and publishes complete 4-digit frames.
module sevenseg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input logic                   clk,
    input logic                   reset_n,
    sevenseg_scan_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [8:0] STABLE_W = 9'(STABLE_CYCLES);

    logic [SYNC_STAGES-1:0][3:0] an_sync_q, an_sync_d;
    logic [SYNC_STAGES-1:0][6:0] seg_sync_q, seg_sync_d;
    logic [3:0]  s_an;
    logic [6:0]  s_seg;
    logic [10:0] sample_s;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [10:0] ref_q, ref_d;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] shadow_val_q, shadow_val_d;
    logic [3:0]  shadow_err_q, shadow_err_d;
    logic [15:0] value_q, value_d;
    logic [3:0]  err_q, err_d;
    logic        fv_q, fv_d;
    logic        capture_s;
    logic [4:0]  dec_s;
    logic [1:0]  dig_s;

    // Returns {err, nibble}; seg is a..g with a in the MSB, 0 = lit.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'b0000001: seg_decode = 5'h00;
            7'b1001111: seg_decode = 5'h01;
            7'b0010010: seg_decode = 5'h02;
            7'b0000110: seg_decode = 5'h03;
            7'b1001100: seg_decode = 5'h04;
            7'b0100100: seg_decode = 5'h05;
            7'b0100000: seg_decode = 5'h06;
            7'b0001111: seg_decode = 5'h07;
            7'b0000000: seg_decode = 5'h08;
            7'b0001100: seg_decode = 5'h09;
            7'b0001000: seg_decode = 5'h0A;
            7'b1100000: seg_decode = 5'h0B;
            7'b0110001: seg_decode = 5'h0C;
            7'b1000010: seg_decode = 5'h0D;
            7'b0110000: seg_decode = 5'h0E;
            7'b0111000: seg_decode = 5'h0F;
            default:    seg_decode = 5'h10;
        endcase
    endfunction

    function automatic logic an_valid(input logic [3:0] an);
        case (an)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: an_valid = 1'b1;
            default:                            an_valid = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        case (an)
            4'b1110: an_index = 2'd0;
            4'b1101: an_index = 2'd1;
            4'b1011: an_index = 2'd2;
            4'b0111: an_index = 2'd3;
            default: an_index = 2'd0;
        endcase
    endfunction

    // Synchronizer shift; stage 0 takes the pin, last stage feeds the logic.
    always_comb begin
        an_sync_d  = {an_sync_q[SYNC_STAGES-2:0], bus.an_in};
        seg_sync_d = {seg_sync_q[SYNC_STAGES-2:0], bus.seg_in};
    end

    assign s_an     = an_sync_q[SYNC_STAGES-1];
    assign s_seg    = seg_sync_q[SYNC_STAGES-1];
    assign sample_s = {s_an, s_seg};

    // Debounce FSM: a digit is captured once its {an, seg} has been stable long enough.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ref_d     = ref_q;
        capture_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (an_valid(s_an)) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd1;
                    ref_d   = sample_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE, ST_HOLD: begin
                if (sample_s == ref_q) begin
                    if (state_q == ST_SETTLE) begin
                        cnt_d = cnt_q + 8'd1;
                        if (({1'b0, cnt_q} + 9'd1) >= STABLE_W) begin
                            capture_s = 1'b1;
                            state_d   = ST_HOLD;
                        end else begin
                            state_d   = ST_SETTLE;
                        end
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else if (an_valid(s_an)) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd1;
                    ref_d   = sample_s;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Shadow capture and frame publication; a same-cycle capture starts the next frame.
    always_comb begin
        dec_s        = seg_decode(ref_q[6:0]);
        dig_s        = an_index(ref_q[10:7]);
        seen_d       = seen_q;
        shadow_val_d = shadow_val_q;
        shadow_err_d = shadow_err_q;
        value_d      = value_q;
        err_d        = err_q;
        fv_d         = 1'b0;
        if (seen_q == 4'hF) begin
            value_d = shadow_val_q;
            err_d   = shadow_err_q;
            fv_d    = 1'b1;
            seen_d  = 4'h0;
        end else begin
            fv_d    = 1'b0;
        end
        if (capture_s) begin
            shadow_val_d[{dig_s, 2'b00} +: 4] = dec_s[3:0];
            shadow_err_d[dig_s]               = dec_s[4];
            seen_d[dig_s]                     = 1'b1;
        end else begin
            seen_d = seen_d;
        end
    end

    // State registers; synchronizers reset to the idle (all-ones) bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_sync_q    <= '1;
            seg_sync_q   <= '1;
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            ref_q        <= 11'd0;
            seen_q       <= 4'h0;
            shadow_val_q <= 16'h0000;
            shadow_err_q <= 4'h0;
            value_q      <= 16'h0000;
            err_q        <= 4'h0;
            fv_q         <= 1'b0;
        end else begin
            an_sync_q    <= an_sync_d;
            seg_sync_q   <= seg_sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ref_q        <= ref_d;
            seen_q       <= seen_d;
            shadow_val_q <= shadow_val_d;
            shadow_err_q <= shadow_err_d;
            value_q      <= value_d;
            err_q        <= err_d;
            fv_q         <= fv_d;
        end
    end

    assign bus.value_out       = value_q;
    assign bus.digit_err_out   = err_q;
    assign bus.frame_valid_out = fv_q;

endmodule
